bcd_stopwatch_counter: RTL

Two-digit BCD seconds stopwatch that produces the 4-bit digit codes for the board's seven-segment decoders.
- Each digit output drives one decoder's a,b,c,d inputs; bit 3 maps to a (MSB) and bit 0 maps to d.
- Takes the board clock and two raw active-low push-buttons: start/stop and clear.
- Internally it synchronises and debounces both buttons, divides the clock down to a 1 Hz tick and counts 00..59 with wrap.

---
 rtl/bcd_stopwatch_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_counter.sv
// rtl/bcd_stopwatch_counter.sv - two-digit BCD seconds stopwatch with debounced start/stop and clear buttons
module bcd_stopwatch_counter #(
   parameter int TICK_DIV   = 50000000,
   parameter int DEB_CYCLES = 500000,
   parameter int MAX_TENS   = 5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       key_ss_n,
   input  logic       key_clr_n,
   output logic [3:0] ones_d,
   output logic [3:0] tens_d,
   output logic       running,
   output logic       wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [PW-1:0] PSC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [3:0]    TENS_LAST = 4'(MAX_TENS);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t          state, state_n;
   logic [1:0]      key_raw, sync1, sync2, stable, stable_d, press;
   logic [DW-1:0]   deb_cnt [2];
   logic [PW-1:0]   psc;
   logic            ss_p, clr_p, tick, last_count;

   // bit 0 = start/stop, bit 1 = clear; all levels are active-low
   assign key_raw = {key_clr_n, key_ss_n};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1    <= '1;
         sync2    <= '1;
         stable   <= '1;
         stable_d <= '1;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync1    <= key_raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // only the accepted press (released -> pressed) edge produces a pulse
   assign press = stable_d & ~stable;
   assign ss_p  = press[0];
   assign clr_p = press[1];

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (ss_p && !clr_p) state_n = RUN;
         RUN:     if (clr_p) state_n = IDLE; else if (ss_p) state_n = PAUSE;
         PAUSE:   if (clr_p) state_n = IDLE; else if (ss_p) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   assign tick       = (state == RUN) && (psc == PSC_LAST);
   assign last_count = (ones_d == 4'd9) && (tens_d == TENS_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         running <= 1'b0;
         wrap    <= 1'b0;
         psc     <= '0;
         ones_d  <= 4'd0;
         tens_d  <= 4'd0;
      end else begin
         state   <= state_n;
         running <= (state_n == RUN);
         wrap    <= tick && last_count && (state_n != IDLE);
         if (state_n == IDLE) begin
            psc    <= '0;
            ones_d <= 4'd0;
            tens_d <= 4'd0;
         end else if (state == RUN) begin
            // a tick taken while leaving RUN for PAUSE still counts
            psc <= tick ? '0 : psc + 1'b1;
            if (tick) begin
               if (ones_d != 4'd9) begin
                  ones_d <= ones_d + 4'd1;
               end else begin
                  ones_d <= 4'd0;
                  tens_d <= (tens_d == TENS_LAST) ? 4'd0 : tens_d + 4'd1;
               end
            end
         end
      end
   end

endmodule
